// File: rtl/vx_dispatch_router_if.sv
// vx_dispatch_router_if: request/response bus between requesters, the
// dispatch router and the downstream target. The master modport is the
// environment side (requesters plus downstream target). The slave modport is the
// router side.
interface vx_dispatch_router_if #(
  parameter int NUM_REQS = 4,
  parameter int ID_W     = 4,
  parameter int SIZE_W   = 8,
  parameter int CORE_W   = 2
);
  logic [NUM_REQS-1:0]        req_valid_in;
  logic [NUM_REQS*ID_W-1:0]   req_id_in;
  logic [NUM_REQS*SIZE_W-1:0] req_size_m1_in;
  logic [NUM_REQS*CORE_W-1:0] req_core_id_in;
  logic [NUM_REQS-1:0]        req_ready_in;
  logic                       req_valid_out;
  logic [ID_W-1:0]            req_id_out;
  logic [SIZE_W-1:0]          req_size_m1_out;
  logic [CORE_W-1:0]          req_core_id_out;
  logic                       req_ready_out;
  logic                       rsp_valid_in;
  logic [ID_W-1:0]            rsp_id_in;
  logic [NUM_REQS-1:0]        rsp_valid_out;
  logic [ID_W-1:0]            rsp_id_out;
  logic                       rsp_err;

  modport master (
    output req_valid_in, req_id_in, req_size_m1_in, req_core_id_in,
    output req_ready_out, rsp_valid_in, rsp_id_in,
    input  req_ready_in, req_valid_out, req_id_out, req_size_m1_out,
    input  req_core_id_out, rsp_valid_out, rsp_id_out, rsp_err
  );

  modport slave (
    input  req_valid_in, req_id_in, req_size_m1_in, req_core_id_in,
    input  req_ready_out, rsp_valid_in, rsp_id_in,
    output req_ready_in, req_valid_out, req_id_out, req_size_m1_out,
    output req_core_id_out, rsp_valid_out, rsp_id_out, rsp_err
  );
endinterface

// File: rtl/vx_dispatch_router.sv
// vx_dispatch_router: round-robin arbiter in front of a one-entry output
// register. An id owner table routes each completion back to the input that
// issued the id, and per-input pending counters limit outstanding requests.
// Optional feature: define VX_DISPATCH_ROUTER_PERF_EN to add the
// perf_stall_cycles port and counter.
module vx_dispatch_router #(
  parameter int NUM_REQS    = 4,
  parameter int ID_W        = 4,
  parameter int SIZE_W      = 8,
  parameter int CORE_W      = 2,
  parameter int MAX_PENDING = 4
) (
  input logic                clk,
  input logic                reset,
  vx_dispatch_router_if.slave bus
`ifdef VX_DISPATCH_ROUTER_PERF_EN
  , output logic [31:0]      perf_stall_cycles
`endif
);

  localparam int IDX_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int PEND_W  = $clog2(MAX_PENDING + 1);
  localparam int NUM_IDS = 1 << ID_W;

  // Round-robin pick: rotate the eligible vector so the pointer sits at bit 0,
  // take the first set bit, then map that bit back to an input index.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQS-1:0] elig,
                                             input logic [IDX_W-1:0]    ptr);
    logic [2*NUM_REQS-1:0] dbl;
    logic [IDX_W:0]        sum;
    logic                  found;
    logic [IDX_W-1:0]      idx;
    dbl   = {elig, elig} >> ptr;
    found = 1'b0;
    idx   = {IDX_W{1'b0}};
    sum   = {(IDX_W+1){1'b0}};
    for (int j = 0; j < NUM_REQS; j++) begin
      if (!found && dbl[j]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IDX_W+1)'(j);
        if (sum >= (IDX_W+1)'(NUM_REQS)) begin
          sum = sum - (IDX_W+1)'(NUM_REQS);
        end else begin
          sum = sum;
        end
        idx = sum[IDX_W-1:0];
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [NUM_REQS-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQS-1:0] oh;
    for (int i = 0; i < NUM_REQS; i++) begin
      oh[i] = (idx == IDX_W'(i));
    end
    return oh;
  endfunction

  logic [PEND_W-1:0]   pending_r [NUM_REQS];
  logic [NUM_IDS-1:0]  busy_r;
  logic [IDX_W-1:0]    owner_r [NUM_IDS];
  logic [IDX_W-1:0]    ptr_r;
  logic                req_valid_out_r;
  logic [ID_W-1:0]     req_id_out_r;
  logic [SIZE_W-1:0]   req_size_out_r;
  logic [CORE_W-1:0]   req_core_out_r;
  logic [NUM_REQS-1:0] rsp_valid_out_r;
  logic [ID_W-1:0]     rsp_id_out_r;
  logic                rsp_err_r;

  logic [NUM_REQS-1:0] eligible_s;
  logic [IDX_W:0]      pick_s;
  logic                grant_found_s;
  logic [IDX_W-1:0]    grant_idx_s;
  logic                out_free_s;
  logic                grant_fire_s;
  logic [NUM_REQS-1:0] req_ready_in_s;
  logic [ID_W-1:0]     sel_id_s;
  logic [SIZE_W-1:0]   sel_size_s;
  logic [CORE_W-1:0]   sel_core_s;
  logic [IDX_W:0]      ptr_inc_s;
  logic [IDX_W-1:0]    ptr_next_s;
  logic                rsp_hit_s;
  logic [NUM_REQS-1:0] rsp_oh_s;

  // Eligibility, arbitration and acceptance of the winning request.
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible_s[i] = bus.req_valid_in[i]
                    && (pending_r[i] < PEND_W'(MAX_PENDING))
                    && !busy_r[bus.req_id_in[i*ID_W +: ID_W]];
    end
    pick_s         = rr_pick(eligible_s, ptr_r);
    grant_found_s  = pick_s[IDX_W];
    grant_idx_s    = pick_s[IDX_W-1:0];
    out_free_s     = !req_valid_out_r || bus.req_ready_out;
    grant_fire_s   = grant_found_s && out_free_s;
    if (grant_fire_s) begin
      req_ready_in_s = to_onehot(grant_idx_s);
    end else begin
      req_ready_in_s = {NUM_REQS{1'b0}};
    end
  end

  // Payload mux for the granted input and next pointer value.
  always_comb begin
    sel_id_s   = {ID_W{1'b0}};
    sel_size_s = {SIZE_W{1'b0}};
    sel_core_s = {CORE_W{1'b0}};
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant_idx_s == IDX_W'(i)) begin
        sel_id_s   = bus.req_id_in[i*ID_W +: ID_W];
        sel_size_s = bus.req_size_m1_in[i*SIZE_W +: SIZE_W];
        sel_core_s = bus.req_core_id_in[i*CORE_W +: CORE_W];
      end else begin
        sel_id_s = sel_id_s;
      end
    end
    ptr_inc_s = {1'b0, grant_idx_s} + (IDX_W+1)'(1);
    if (ptr_inc_s >= (IDX_W+1)'(NUM_REQS)) begin
      ptr_next_s = {IDX_W{1'b0}};
    end else begin
      ptr_next_s = ptr_inc_s[IDX_W-1:0];
    end
  end

  // Completion lookup: a hit needs a busy entry; its owner gets the one-hot bit.
  always_comb begin
    rsp_hit_s = bus.rsp_valid_in && busy_r[bus.rsp_id_in];
    if (rsp_hit_s) begin
      rsp_oh_s = to_onehot(owner_r[bus.rsp_id_in]);
    end else begin
      rsp_oh_s = {NUM_REQS{1'b0}};
    end
  end

  // One-entry output register: load on accepted grant, empty on drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_valid_out_r <= 1'b0;
      req_id_out_r    <= {ID_W{1'b0}};
      req_size_out_r  <= {SIZE_W{1'b0}};
      req_core_out_r  <= {CORE_W{1'b0}};
    end else if (out_free_s) begin
      req_valid_out_r <= grant_fire_s;
      if (grant_fire_s) begin
        req_id_out_r   <= sel_id_s;
        req_size_out_r <= sel_size_s;
        req_core_out_r <= sel_core_s;
      end
    end
  end

  // Round-robin pointer moves past the input that won an accepted grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= {IDX_W{1'b0}};
    end else if (grant_fire_s) begin
      ptr_r <= ptr_next_s;
    end
  end

  // Per-input outstanding counters; a grant and a completion together cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQS; i++) pending_r[i] <= PEND_W'(0);
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (req_ready_in_s[i] && !rsp_oh_s[i]) begin
          pending_r[i] <= pending_r[i] + PEND_W'(1);
        end else if (rsp_oh_s[i] && !req_ready_in_s[i]) begin
          pending_r[i] <= pending_r[i] - PEND_W'(1);
        end
      end
    end
  end

  // Owner table: a completion frees its id; a grant claims a (different) free id.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= {NUM_IDS{1'b0}};
      for (int k = 0; k < NUM_IDS; k++) owner_r[k] <= {IDX_W{1'b0}};
    end else begin
      if (rsp_hit_s) begin
        busy_r[bus.rsp_id_in] <= 1'b0;
      end
      if (grant_fire_s) begin
        busy_r[sel_id_s]  <= 1'b1;
        owner_r[sel_id_s] <= grant_idx_s;
      end
    end
  end

  // Registered completion routing and no-owner error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_out_r <= {NUM_REQS{1'b0}};
      rsp_id_out_r    <= {ID_W{1'b0}};
      rsp_err_r       <= 1'b0;
    end else begin
      rsp_valid_out_r <= rsp_oh_s;
      rsp_id_out_r    <= bus.rsp_id_in;
      rsp_err_r       <= bus.rsp_valid_in && !busy_r[bus.rsp_id_in];
    end
  end

`ifdef VX_DISPATCH_ROUTER_PERF_EN
  logic [31:0] perf_stall_r;

  // Saturating count of cycles where someone asked and nothing was accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_r <= 32'd0;
    end else if ((|bus.req_valid_in) && !grant_fire_s && (perf_stall_r != 32'hFFFF_FFFF)) begin
      perf_stall_r <= perf_stall_r + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_r;
`endif

  assign bus.req_ready_in    = req_ready_in_s;
  assign bus.req_valid_out   = req_valid_out_r;
  assign bus.req_id_out      = req_id_out_r;
  assign bus.req_size_m1_out = req_size_out_r;
  assign bus.req_core_id_out = req_core_out_r;
  assign bus.rsp_valid_out   = rsp_valid_out_r;
  assign bus.rsp_id_out      = rsp_id_out_r;
  assign bus.rsp_err         = rsp_err_r;

endmodule

// File: tb/tb_vx_dispatch_router.sv
// tb_vx_dispatch_router: directed scenarios followed by random traffic. The
// reference model keeps, for each id, which input owns it, plus per-input
// outstanding counts and an output-slot occupancy flag. Expected
// transactions go to queues that a separate monitor drains.
module tb_vx_dispatch_router;
  localparam int N    = 4;
  localparam int IW   = 4;
  localparam int SW   = 8;
  localparam int CW   = 2;
  localparam int MAXP = 2;
  localparam int NIDS = 16;
  localparam int IXW  = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [SW-1:0] size;
    logic [CW-1:0] core;
  } req_t;

  typedef struct packed {
    logic [N-1:0]  oh;
    logic [IW-1:0] id;
    logic          err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vx_dispatch_router_if #(.NUM_REQS(N), .ID_W(IW), .SIZE_W(SW), .CORE_W(CW)) bus ();

`ifdef VX_DISPATCH_ROUTER_PERF_EN
  logic [31:0] perf;
`endif

  vx_dispatch_router #(
    .NUM_REQS(N), .ID_W(IW), .SIZE_W(SW), .CORE_W(CW), .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef VX_DISPATCH_ROUTER_PERF_EN
    , .perf_stall_cycles(perf)
`endif
  );

  int checks = 0;
  int failures = 0;
  req_t req_q[$];
  rsp_t rsp_q[$];
  int owner [NIDS];
  int pend [N];
  logic [IXW-1:0] ptr;
  bit m_full;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NIDS; i++) owner[i] = -1;
    for (int i = 0; i < N; i++) pend[i] = 0;
    ptr = '0;
    m_full = 1'b0;
    req_q.delete();
    rsp_q.delete();
  endtask

  task automatic drive_idle();
    bus.req_valid_in   = '0;
    bus.req_id_in      = '0;
    bus.req_size_m1_in = '0;
    bus.req_core_id_in = '0;
    bus.req_ready_out  = 1'b1;
    bus.rsp_valid_in   = 1'b0;
    bus.rsp_id_in      = '0;
  endtask

  // One clock of stimulus; the model predicts the grant and queues outcomes.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0][IW-1:0] ids,
                      input bit rdy, input bit rv, input logic [IW-1:0] rid);
    logic [N-1:0][SW-1:0] szp;
    logic [N-1:0][CW-1:0] crp;
    logic [N-1:0]   exp_rdy;
    logic [IXW-1:0] c;
    logic [IXW-1:0] gi;
    logic [IXW-1:0] o;
    int   g;
    bit   acc;
    rsp_t s;
    @(negedge clk);
    szp = (N*SW)'($urandom);
    crp = (N*CW)'($urandom);
    bus.req_valid_in   = v;
    bus.req_id_in      = ids;
    bus.req_size_m1_in = szp;
    bus.req_core_id_in = crp;
    bus.req_ready_out  = rdy;
    bus.rsp_valid_in   = rv;
    bus.rsp_id_in      = rid;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      c = IXW'((int'(ptr) + k) % N);
      if (g < 0 && v[c] && pend[c] < MAXP && owner[ids[c]] < 0) g = int'(c);
    end
    acc = (g >= 0) && (!m_full || rdy);
    gi = IXW'((g < 0) ? 0 : g);
    exp_rdy = '0;
    if (acc) exp_rdy[gi] = 1'b1;
    check("req_ready_in", bus.req_ready_in, exp_rdy);
    if (acc) begin
      req_q.push_back('{id: ids[gi], size: szp[gi], core: crp[gi]});
      m_full = 1'b1;
    end else if (rdy) begin
      m_full = 1'b0;
    end
    if (rv) begin
      s.oh = '0;
      s.id = rid;
      if (owner[rid] >= 0) begin
        o = IXW'(owner[rid]);
        s.oh[o] = 1'b1;
        s.err = 1'b0;
        pend[o]--;
        owner[rid] = -1;
      end else begin
        s.err = 1'b1;
      end
      rsp_q.push_back(s);
    end
    if (acc) begin
      owner[ids[gi]] = g;
      pend[gi]++;
      ptr = IXW'((g + 1) % N);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #3;
    check("reset_req_valid_out", bus.req_valid_out, 1'b0);
    check("reset_rsp_valid_out", bus.rsp_valid_out, 4'b0000);
    check("reset_rsp_err", bus.rsp_err, 1'b0);
`ifdef VX_DISPATCH_ROUTER_PERF_EN
    check("reset_perf", perf, 32'd0);
`endif
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a transaction.
  initial begin : monitor
    req_t er;
    rsp_t es;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        if (bus.req_valid_out && bus.req_ready_out) begin
          check("req_out_expected", req_q.size() != 0, 1'b1);
          if (req_q.size() != 0) begin
            er = req_q.pop_front();
            check("req_out", {bus.req_id_out, bus.req_size_m1_out, bus.req_core_id_out}, er);
          end
        end
        if (bus.rsp_valid_out != '0 || bus.rsp_err) begin
          check("rsp_out_expected", rsp_q.size() != 0, 1'b1);
          if (rsp_q.size() != 0) begin
            es = rsp_q.pop_front();
            check("rsp_valid_out", bus.rsp_valid_out, es.oh);
            check("rsp_err", bus.rsp_err, es.err);
            if (!es.err) check("rsp_id_out", bus.rsp_id_out, es.id);
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0][IW-1:0] ids;
    logic [N-1:0][IW-1:0] z;
    logic [IW-1:0] rid;
    int bl[$];
    z = '0;
    drive_idle();
    do_reset();

    // Round robin with all inputs valid and distinct ids.
    for (int t = 0; t < 5; t++) begin
      ids = (t < 4) ? {4'd3, 4'd2, 4'd1, 4'd0} : {4'd7, 4'd6, 4'd5, 4'd4};
      step(4'b1111, ids, 1'b1, 1'b0, 4'd0);
    end
    for (int i = 0; i < 5; i++) step('0, z, 1'b1, 1'b1, IW'(i));

    // Inputs 0 and 2 contend for id 5; input 2 waits for the completion.
    do_reset();
    ids = {4'd0, 4'd5, 4'd0, 4'd5};
    step(4'b0101, ids, 1'b1, 1'b0, 4'd0);
    step(4'b0100, ids, 1'b1, 1'b0, 4'd0);
    step(4'b0100, ids, 1'b1, 1'b0, 4'd0);
    step(4'b0100, ids, 1'b1, 1'b1, 4'd5);
    step(4'b0100, ids, 1'b1, 1'b0, 4'd0);
    step('0, z, 1'b1, 1'b1, 4'd5);

    // Completion for an id never issued.
    step('0, z, 1'b1, 1'b1, 4'd9);

    // Pending limit: input 1 issues ids 1,2,3.
    do_reset();
    step(4'b0010, {4'd0, 4'd0, 4'd1, 4'd0}, 1'b1, 1'b0, 4'd0);
    step(4'b0010, {4'd0, 4'd0, 4'd2, 4'd0}, 1'b1, 1'b0, 4'd0);
    step(4'b0010, {4'd0, 4'd0, 4'd3, 4'd0}, 1'b1, 1'b0, 4'd0);
    step(4'b0010, {4'd0, 4'd0, 4'd3, 4'd0}, 1'b1, 1'b1, 4'd1);
    step(4'b0010, {4'd0, 4'd0, 4'd3, 4'd0}, 1'b1, 1'b0, 4'd0);

    // Backpressure: output full and downstream stalled for 3 cycles.
    step(4'b0001, {4'd0, 4'd0, 4'd0, 4'd10}, 1'b0, 1'b0, 4'd0);
    for (int t = 0; t < 3; t++) step(4'b1000, {4'd11, 4'd0, 4'd0, 4'd0}, 1'b0, 1'b0, 4'd0);
    step(4'b1000, {4'd11, 4'd0, 4'd0, 4'd0}, 1'b1, 1'b0, 4'd0);
    step('0, z, 1'b1, 1'b0, 4'd0);

    // Reset with three ids outstanding, then complete them.
    do_reset();
    for (int t = 0; t < 3; t++) step(4'b0111, {4'd0, 4'd14, 4'd13, 4'd12}, 1'b1, 1'b0, 4'd0);
    do_reset();
    for (int i = 12; i < 15; i++) step('0, z, 1'b1, 1'b1, IW'(i));

    // Random traffic.
    for (int t = 0; t < 3000; t++) begin
      bl.delete();
      for (int i = 0; i < NIDS; i++) if (owner[i] >= 0) bl.push_back(i);
      if (bl.size() > 0 && ($urandom % 5) != 0) rid = IW'(bl[$urandom % bl.size()]);
      else rid = IW'($urandom);
      step(N'($urandom), (N*IW)'($urandom), ($urandom % 4) != 0, ($urandom % 3) == 0, rid);
    end

    // Drain and confirm every expected transaction appeared.
    for (int t = 0; t < 6; t++) step('0, z, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    #3;
    check("req_q_empty", req_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vx_dispatch_router.md
VX_DISPATCH_ROUTER -- requirements
Module: VX_dispatch_router

Interface
REQ-001 Parameter NUM_REQS, default 4: number of requesting inputs, range 1..16.
REQ-002 Parameter ID_W, default 4: request/response id width; the owner table has 2^ID_W entries.
REQ-003 Parameter SIZE_W, default 8: req_size_m1 width.
REQ-004 Parameter CORE_W, default 2: req_core_id width.
REQ-005 Parameter MAX_PENDING, default 4: maximum outstanding requests per input, range 1..2^ID_W.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 req_valid_in  input  NUM_REQS  per-input request valid.
REQ-009 req_id_in  input  NUM_REQS*ID_W  per-input request id.
REQ-010 req_size_m1_in  input  NUM_REQS*SIZE_W  per-input size minus one.
REQ-011 req_core_id_in  input  NUM_REQS*CORE_W  per-input core id.
REQ-012 req_ready_in  output  NUM_REQS  per-input accept.
REQ-013 req_valid_out, req_id_out, req_size_m1_out, req_core_id_out  output  1/ID_W/SIZE_W/CORE_W  registered arbitrated request.
REQ-014 req_ready_out  input  1  downstream accept.
REQ-015 rsp_valid_in, rsp_id_in  input  1/ID_W  completion from downstream; no backpressure.
REQ-016 rsp_valid_out  output  NUM_REQS  one-hot completion routed to owning input.
REQ-017 rsp_id_out  output  ID_W  registered completion id, shared by all inputs.
REQ-018 rsp_err  output  1  one-cycle pulse: completion id had no owner.

Function
REQ-019 Input i is eligible when req_valid_in[i]=1, pending[i]<MAX_PENDING, and owner-table entry req_id_in[i] is not busy.
REQ-020 Grant is round-robin: search starts at pointer ptr; ptr advances to (granted index+1) mod NUM_REQS after each accepted grant; ptr is unchanged when nothing is granted.
REQ-021 Output stage is a one-entry register; a grant is accepted when the register is empty or req_valid_out and req_ready_out are both 1 in the same cycle.
REQ-022 req_ready_in is one-hot-or-zero and high only for the granted input in a cycle where the grant is accepted; the path is combinational from inputs.
REQ-023 Latency: request accepted in cycle N appears on req_* outputs in cycle N+1; output holds stable while req_valid_out=1 and req_ready_out=0.
REQ-024 On acceptance: table[id].busy<=1, table[id].owner<=i, pending[i]+=1.
REQ-025 On rsp_valid_in in cycle N with a busy entry: in cycle N+1, rsp_valid_out has a single 1 at the owner bit and rsp_id_out=rsp_id_in; the entry clears and owner pending decrements at the end of N.
REQ-026 On rsp_valid_in with a non-busy entry: rsp_valid_out=0 and rsp_err=1 in N+1; no state changes.
REQ-027 Same-cycle accept and completion for the same input: pending[i] is unchanged (net zero).
REQ-028 Same id in request and completion in the same cycle: the request sees the old busy=1 and is stalled; it becomes eligible in N+1.
REQ-029 Duplicate outstanding id: a request is never granted while its id is busy, even when another input owns that id.
REQ-030 pending[i] width is clog2(MAX_PENDING+1); it never over- or underflows.

Reset
REQ-031 Reset drives req_valid_out=0, rsp_valid_out=0, rsp_err=0, ptr=0, all pending=0, and all busy=0 asynchronously; data registers are don't-care.
REQ-032 Reset mid-operation discards the in-flight output entry and all ownership; later completions for those ids produce rsp_err.

Configuration
REQ-033 With VX_DISPATCH_ROUTER_PERF_EN defined: output perf_stall_cycles [31:0] counts cycles with any req_valid_in=1 and no accepted grant, saturating at 2^32-1 and reset to 0.
REQ-034 Without VX_DISPATCH_ROUTER_PERF_EN: the perf_stall_cycles port and counter are absent; all other behaviour is identical.

Verification
REQ-035 NUM_REQS=4, all inputs valid with distinct ids, req_ready_out=1 -> grants 0,1,2,3,0 on consecutive cycles, and req_valid_out is continuous from cycle 1.
REQ-036 Inputs 0 and 2 both request id=5 -> input 0 is granted; input 2 is stalled until rsp_id_in=5; rsp_valid_out=4'b0001 the next cycle; input 2 is granted one cycle after the completion.
REQ-037 MAX_PENDING=2, input 1 issues ids 1,2,3 -> third request is held (req_ready_in[1]=0) until a completion for id 1 or 2 arrives.
REQ-038 req_ready_out=0 for 3 cycles with output full -> req_* outputs stay stable and req_ready_in=0; the held entry drains one cycle after req_ready_out=1.
REQ-039 rsp_valid_in with id=9, never issued -> rsp_err=1 for one cycle, rsp_valid_out=0.
REQ-040 Assert reset with 3 outstanding ids, then send completions for them -> three rsp_err pulses; with PERF_EN, perf_stall_cycles reads 0 after reset.
